// File: rtl/io_pkg.sv
// Shared I/O opcode definitions and decode helper, also used by the control-unit decoder.
package io_pkg;

    localparam int DATA_W = 32;
    localparam int OPC_W  = 6;

    localparam logic [OPC_W-1:0] OPC_IN  = 6'b111110;
    localparam logic [OPC_W-1:0] OPC_OUT = 6'b111101;

    typedef enum logic [1:0] {
        IO_NOP = 2'd0,
        IO_IN  = 2'd1,
        IO_OUT = 2'd2
    } io_op_e;

    // An X/Z opcode makes both equalities unknown, so it falls through to IO_NOP.
    function automatic io_op_e decodeOp(input logic [OPC_W-1:0] opc);
        if (opc == OPC_IN) begin
            return IO_IN;
        end else if (opc == OPC_OUT) begin
            return IO_OUT;
        end else begin
            return IO_NOP;
        end
    endfunction

endpackage

// File: rtl/io_in_sync.sv
// Two-flop synchronizer for the external input bus; only used under IO_MODULE_INPUT_SYNC_EN.
module io_in_sync
    import io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_stage1;
    logic [DATA_W-1:0] r_stage2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1 <= i_data;
            r_stage2 <= r_stage1;
        end
    end

    assign o_data = r_stage2;

endmodule

// File: rtl/io_module.sv
// I/O port unit: IN captures the input bus for a register-file write, OUT drives the captured value out.
// Optional feature macro: IO_MODULE_INPUT_SYNC_EN adds a two-flop synchronizer on in_data.
module io_module
    import io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OPC_W-1:0]  control_signal,
    input  logic [DATA_W-1:0] in_data,
    output logic              RF_from_IO,
    output logic [DATA_W-1:0] out_data,
    output logic              io_we,
    output logic [DATA_W-1:0] io_rd_data
);

    logic [DATA_W-1:0] r_ioReg;
    logic [DATA_W-1:0] w_inData;
    io_op_e            w_op;

`ifdef IO_MODULE_INPUT_SYNC_EN
    io_in_sync u_inSync (
        .clk    (clk),
        .rst    (rst),
        .i_data (in_data),
        .o_data (w_inData)
    );
`else
    assign w_inData = in_data;
`endif

    always_comb begin
        w_op = decodeOp(control_signal);
    end

    // Strobes are recomputed every edge so they last exactly as long as the opcode is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ioReg    <= '0;
            io_rd_data <= '0;
            out_data   <= '0;
            io_we      <= 1'b0;
            RF_from_IO <= 1'b0;
        end else begin
            io_we      <= 1'b0;
            RF_from_IO <= 1'b0;
            case (w_op)
                IO_IN: begin
                    r_ioReg    <= w_inData;
                    io_rd_data <= w_inData;
                    io_we      <= 1'b1;
                end
                IO_OUT: begin
                    out_data   <= r_ioReg;
                    RF_from_IO <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_module.sv
// Self-checking bench for io_module: directed literal checks plus randomized stimulus vs. a behavioural model.
// Honours IO_MODULE_INPUT_SYNC_EN the same way the design does.
module tb_io_module;

    localparam logic [5:0] OPC_IN  = 6'b111110;
    localparam logic [5:0] OPC_OUT = 6'b111101;

    logic        clk;
    logic        rst;
    logic [5:0]  control_signal;
    logic [31:0] in_data;
    logic        RF_from_IO;
    logic [31:0] out_data;
    logic        io_we;
    logic [31:0] io_rd_data;

    int checks   = 0;
    int failures = 0;
    bit cmpEn    = 1'b0;

    // Behavioural model state: what the outputs must be after the last edge.
    logic [31:0] mIoReg, mRd, mOut;
    logic        mWe, mRf;
    logic [31:0] hist [2];

    io_module dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (control_signal),
        .in_data        (in_data),
        .RF_from_IO     (RF_from_IO),
        .out_data       (out_data),
        .io_we          (io_we),
        .io_rd_data     (io_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mIoReg  = '0;
        mRd     = '0;
        mOut    = '0;
        mWe     = 1'b0;
        mRf     = 1'b0;
        hist[0] = '0;
        hist[1] = '0;
    endtask

    // One clock edge with the given opcode and data; the model advances with it.
    task automatic applyStimulus(input logic [5:0] ctrl, input logic [31:0] data);
        logic [31:0] captured;
        control_signal = ctrl;
        in_data        = data;
        @(posedge clk);
`ifdef IO_MODULE_INPUT_SYNC_EN
        captured = hist[1];
        hist[1]  = hist[0];
        hist[0]  = data;
`else
        captured = data;
`endif
        if (ctrl === OPC_IN) begin
            mIoReg = captured;
            mRd    = captured;
            mWe    = 1'b1;
            mRf    = 1'b0;
        end else if (ctrl === OPC_OUT) begin
            mOut = mIoReg;
            mRf  = 1'b1;
            mWe  = 1'b0;
        end else begin
            mWe = 1'b0;
            mRf = 1'b0;
        end
        #2;
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_io_we"},      {31'b0, io_we},      32'h0);
        checkOutput({tag, "_rf_from_io"}, {31'b0, RF_from_IO}, 32'h0);
        checkOutput({tag, "_io_rd_data"}, io_rd_data,          32'h0);
        checkOutput({tag, "_out_data"},   out_data,            32'h0);
    endtask

    // Holds reset across one edge and releases it mid-cycle.
    task automatic pulseReset(input string tag);
        rst = 1'b1;
        modelReset();
        #1;
        checkZeros(tag);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("cmp_io_we",      {31'b0, io_we},      {31'b0, mWe});
            checkOutput("cmp_rf_from_io", {31'b0, RF_from_IO}, {31'b0, mRf});
            checkOutput("cmp_io_rd_data", io_rd_data,          mRd);
            checkOutput("cmp_out_data",   out_data,            mOut);
        end
    end

    initial begin
        logic [5:0]  ctrl;
        logic [31:0] data;
        rst            = 1'b0;
        control_signal = 6'b000000;
        in_data        = 32'h0;
        modelReset();
        #1;
        pulseReset("reset_async");
        cmpEn = 1'b1;

        // Hold in_data for two idle edges so a synchronized build sees it too.
        applyStimulus(6'b000000, 32'hAABBCCDD);
        applyStimulus(6'b000000, 32'hAABBCCDD);
        applyStimulus(OPC_IN, 32'hAABBCCDD);
        checkOutput("in_io_we",      {31'b0, io_we},      32'h1);
        checkOutput("in_io_rd_data", io_rd_data,          32'hAABBCCDD);
        checkOutput("in_rf_from_io", {31'b0, RF_from_IO}, 32'h0);

        applyStimulus(OPC_OUT, 32'h0);
        checkOutput("out_rf_from_io", {31'b0, RF_from_IO}, 32'h1);
        checkOutput("out_io_we",      {31'b0, io_we},      32'h0);
        checkOutput("out_out_data",   out_data,            32'hAABBCCDD);
        checkOutput("out_io_rd_data", io_rd_data,          32'hAABBCCDD);

        applyStimulus(6'b000011, 32'h12345678);
        checkOutput("inv_io_we",      {31'b0, io_we},      32'h0);
        checkOutput("inv_rf_from_io", {31'b0, RF_from_IO}, 32'h0);
        checkOutput("inv_out_data",   out_data,            32'hAABBCCDD);
        checkOutput("inv_io_rd_data", io_rd_data,          32'hAABBCCDD);

        applyStimulus(6'bxxxxxx, 32'h12345678);
        checkOutput("x_opc_io_we", {31'b0, io_we}, 32'h0);

        pulseReset("reset_mid");
        applyStimulus(6'b000000, 32'h0);
        checkZeros("reset_idle");

        applyStimulus(OPC_IN, 32'h11111111);
`ifndef IO_MODULE_INPUT_SYNC_EN
        checkOutput("b2b_first_rd", io_rd_data, 32'h11111111);
`endif
        applyStimulus(OPC_IN, 32'h22222222);
        checkOutput("b2b_io_we", {31'b0, io_we}, 32'h1);
`ifndef IO_MODULE_INPUT_SYNC_EN
        checkOutput("b2b_second_rd", io_rd_data, 32'h22222222);
`endif
        applyStimulus(OPC_OUT, 32'h0);
`ifndef IO_MODULE_INPUT_SYNC_EN
        checkOutput("b2b_out_data", out_data, 32'h22222222);
`endif
        applyStimulus(OPC_OUT, 32'h0);
        checkOutput("b2b_out_rf", {31'b0, RF_from_IO}, 32'h1);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ctrl = OPC_IN;
                4, 5, 6:    ctrl = OPC_OUT;
                default:    ctrl = 6'($urandom);
            endcase
            data = $urandom;
            if ($urandom_range(0, 49) == 0) begin
                pulseReset("reset_rand");
            end else begin
                applyStimulus(ctrl, data);
            end
        end

        applyStimulus(6'b000000, 32'h0);
        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
